// File: rtl/excess3_pkg.sv
// Shared types and constants for the excess-3 request scheduler.
// The optional parity output is enabled with EXCESS3_PARITY_EN.
package excess3_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    SEND
  } state_t;

  localparam int N_REQ  = 10;
  localparam int M_W    = 4;
  localparam int E3_OFF = 3;
  localparam int CNT_W  = 8;

endpackage

// File: rtl/excess3_10x4.sv
// One-hot digit select to excess-3 code; anything not one-hot maps to zero.
// Purely combinational; the scheduler drives it from its grant register.
module excess3_10x4
  import excess3_pkg::*;
#(
  parameter int N = N_REQ,
  parameter int M = M_W
) (
  input  logic [N-1:0] onehot,
  output logic [M-1:0] code
);

  logic legal;

  assign legal = (onehot != '0) &&
                 ((onehot & (onehot - N'(1))) == '0);

  always_comb begin
    code = '0;
    for (int i = 0; i < N; i++) begin
      if (legal && onehot[i]) begin
        code = M'(i + E3_OFF);
      end
    end
  end

endmodule

// File: rtl/excess3_req_scheduler.sv
// Round-robin digit arbiter sending excess-3 codes over valid/ready.
// Define EXCESS3_PARITY_EN to add the registered odd-parity output out_par.
module excess3_req_scheduler
  import excess3_pkg::*;
#(
  parameter int N = N_REQ,
  parameter int M = M_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     ack,
  output logic [M-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
`ifdef EXCESS3_PARITY_EN
  output logic             out_par,
`endif
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam int PW = $clog2(N);

  state_t           state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [M-1:0]     data_q, data_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             par_q, par_d;

  logic [N-1:0]     pick;
  logic             found;
  logic [PW-1:0]    gidx;
  logic [M-1:0]     enc;
  logic             hs;

  excess3_10x4 #(.N(N), .M(M)) u_enc (
    .onehot (grant_q),
    .code   (enc)
  );

  // First pass searches at/above ptr, second pass wraps from bit 0.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && i >= int'(ptr_q) && req[i]) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) gidx = PW'(i);
    end
  end

  assign hs = (state_q == SEND) && valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    unique case (state_q)
      IDLE: begin
        if (req != '0) begin
          grant_d = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        data_d  = enc;
        valid_d = 1'b1;
        par_d   = ~^enc;
        state_d = SEND;
      end
      SEND: begin
        if (hs) begin
          data_d  = '0;
          valid_d = 1'b0;
          par_d   = 1'b0;
          grant_d = '0;
          ptr_d   = (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
          cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
    end
  end

  assign ack       = hs ? grant_q : '0;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = (state_q != IDLE);
  assign xfer_cnt  = cnt_q;
`ifdef EXCESS3_PARITY_EN
  assign out_par   = par_q;
`else
  logic unused_par;
  assign unused_par = par_q;
`endif

endmodule

// File: tb/tb_excess3_req_scheduler.sv
// Directed bench for excess3_req_scheduler (parity checks need EXCESS3_PARITY_EN).
module tb_excess3_req_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [9:0] req = '0;
  logic [9:0] ack;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       busy;
  logic [7:0] xfer_cnt;
`ifdef EXCESS3_PARITY_EN
  logic       out_par;
`endif

  int checks   = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  excess3_req_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .ack       (ack),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
`ifdef EXCESS3_PARITY_EN
    .out_par   (out_par),
`endif
    .xfer_cnt  (xfer_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 20);
    chk({tag, "_timeout"}, 32'(out_valid), 32'd1);
  endtask

  logic [3:0] exp_code [3];
  logic [9:0] exp_ack  [3];

  initial begin
    exp_code[0] = 4'h3; exp_code[1] = 4'hC; exp_code[2] = 4'h3;
    exp_ack[0]  = 10'h001; exp_ack[1] = 10'h200; exp_ack[2] = 10'h001;

    // reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data",  32'(out_data),  0);
    chk("rst_busy",  32'(busy),      0);
    chk("rst_cnt",   32'(xfer_cnt),  0);
    chk("rst_ack",   32'(ack),       0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // single digit 0
    req = 10'h001; out_ready = 1'b1;
    wait_valid("d0", n);
    chk("d0_lat",  32'(n),        2);
    chk("d0_data", 32'(out_data), 4'h3);
    chk("d0_ack",  32'(ack),      10'h001);
    chk("d0_busy", 32'(busy),     1);
    req = '0;
    @(negedge clk);
    chk("d0_vlow", 32'(out_valid), 0);
    chk("d0_dlow", 32'(out_data),  0);
    chk("d0_ackz", 32'(ack),       0);
    chk("d0_cnt",  32'(xfer_cnt),  1);

    // reset so arbitration restarts at ptr 0, then alternate 0/9/0
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    chk("rr_cnt0", 32'(xfer_cnt), 0);
    req = 10'h201;
    for (int k = 0; k < 3; k++) begin
      wait_valid("rr", n);
      chk("rr_lat",  32'(n),        (k == 0) ? 2 : 3);
      chk("rr_data", 32'(out_data), 32'(exp_code[k]));
      chk("rr_ack",  32'(ack),      32'(exp_ack[k]));
      if (k == 2) req = '0;
    end
    @(negedge clk);
    chk("rr_cnt", 32'(xfer_cnt), 3);

    // digit 5 with backpressure; request dropped during SEND
    req = 10'h020; out_ready = 1'b0;
    wait_valid("bp", n);
    req = '0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_data", 32'(out_data),  4'h8);
      chk("bp_vld",  32'(out_valid), 1);
      chk("bp_ack0", 32'(ack),       0);
`ifdef EXCESS3_PARITY_EN
      chk("bp_par", 32'(out_par), 0);
`endif
      @(negedge clk);
    end
    chk("bp_hold", 32'(out_data), 4'h8);
    out_ready = 1'b1;
    #1;
    chk("bp_ack", 32'(ack), 10'h020);
    @(negedge clk);
    chk("bp_vlow", 32'(out_valid), 0);
    chk("bp_ackz", 32'(ack),       0);
    chk("bp_cnt",  32'(xfer_cnt),  4);

    // digit 4
    req = 10'h010;
    wait_valid("d4", n);
    chk("d4_data", 32'(out_data), 4'h7);
`ifdef EXCESS3_PARITY_EN
    chk("d4_par", 32'(out_par), 0);
`endif
    req = '0;
    @(negedge clk);
    chk("d4_cnt", 32'(xfer_cnt), 5);

    // digit 2, reset during SEND
    req = 10'h004; out_ready = 1'b0;
    wait_valid("d2", n);
    chk("d2_data", 32'(out_data), 4'h5);
`ifdef EXCESS3_PARITY_EN
    chk("d2_par", 32'(out_par), 1);
`endif
    #2 rst_n = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("ra_valid", 32'(out_valid), 0);
    chk("ra_data",  32'(out_data),  0);
    chk("ra_ack",   32'(ack),       0);
    chk("ra_busy",  32'(busy),      0);
    chk("ra_cnt",   32'(xfer_cnt),  0);
`ifdef EXCESS3_PARITY_EN
    chk("ra_par", 32'(out_par), 0);
`endif
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // ready while idle has no effect
    repeat (3) @(negedge clk);
    chk("idle_rdy_cnt", 32'(xfer_cnt),  0);
    chk("idle_rdy_vld", 32'(out_valid), 0);
    chk("idle_rdy_ack", 32'(ack),       0);

    // saturation after 300 transfers
    req = 10'h3FF;
    repeat (300 * 3 + 10) @(negedge clk);
    chk("sat_cnt", 32'(xfer_cnt), 255);
    req = '0;
    repeat (4) @(negedge clk);
    chk("sat_hold", 32'(xfer_cnt), 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
